// File: rtl/axis_video_pattern_gen_if.sv
// AXI4-Stream video bus: 24-bit RGB pixel with start-of-frame (tuser) and end-of-line (tlast).
interface axis_video_pattern_gen_if;
    logic [23:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tuser;
    logic        tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/axis_video_pattern_gen.sv
// Synthetic AXI4-Stream video source: fixed-geometry frames with programmable line/frame
// idle gaps, four test patterns and full backpressure support.
module axis_video_pattern_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720,
    parameter int H_GAP    = 16,
    parameter int V_GAP    = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic [1:0]                      pattern_sel,
    axis_video_pattern_gen_if.master        m_axis_video,
    output logic                            frame_done,
    output logic [15:0]                     frame_num
);

    // Coordinates are at least 8 bits wide so the ramp/coordinate/checker bit selects always exist.
    localparam int XW    = ($clog2(H_ACTIVE) > 8) ? $clog2(H_ACTIVE) : 8;
    localparam int YW    = ($clog2(V_ACTIVE) > 8) ? $clog2(V_ACTIVE) : 8;
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW    = (BAR_W > 2) ? $clog2(BAR_W) : 1;
    localparam int GMAX  = (H_GAP > V_GAP) ? H_GAP : V_GAP;
    localparam int GW    = (GMAX > 2) ? $clog2(GMAX) : 1;

    localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
    localparam logic [GW-1:0] H_GAP_LD = GW'((H_GAP > 0) ? H_GAP - 1 : 0);
    localparam logic [GW-1:0] V_GAP_LD = GW'((V_GAP > 0) ? V_GAP - 1 : 0);

    typedef enum logic [1:0] {IDLE, ACTIVE, HGAP, VGAP} state_t;

    state_t          state_q;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    logic [2:0]      bar_q;
    logic [BW-1:0]   bar_cnt_q;
    logic [GW-1:0]   gap_q;
    logic [1:0]      sel_q;
    logic [23:0]     tdata_q;
    logic            tvalid_q;
    logic            tuser_q;
    logic            tlast_q;
    logic            frame_done_q;
    logic [15:0]     frame_num_q;

    logic [XW-1:0]   x_inc_d;
    logic [YW-1:0]   y_inc_d;
    logic [2:0]      bar_d;
    logic [BW-1:0]   bar_cnt_d;
    logic [15:0]     frame_num_d;
    logic            bar_wrap;

    function automatic logic [23:0] bar_colour(input logic [2:0] bar);
        case (bar)
            3'd0:    return 24'hFFFFFF;
            3'd1:    return 24'hFFFF00;
            3'd2:    return 24'h00FFFF;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'hFF00FF;
            3'd5:    return 24'hFF0000;
            3'd6:    return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] pixel(input logic [1:0]    sel,
                                          input logic [XW-1:0] x,
                                          input logic [YW-1:0] y,
                                          input logic [15:0]   fnum,
                                          input logic [2:0]    bar);
        case (sel)
            2'd0:    return bar_colour(bar);
            2'd1:    return {3{x[7:0]}};
            2'd2:    return (x[5] ^ y[5]) ? 24'hFFFFFF : 24'h000000;
            default: return {fnum[7:0], y[7:0], x[7:0]};
        endcase
    endfunction

    // Bar index advances from a per-bar pixel counter, so no divider is needed.
    assign bar_wrap    = (bar_cnt_q == BAR_LAST);
    assign bar_cnt_d   = bar_wrap ? '0 : bar_cnt_q + 1'b1;
    assign bar_d       = bar_wrap ? bar_q + 3'd1 : bar_q;
    assign x_inc_d     = x_q + 1'b1;
    assign y_inc_d     = y_q + 1'b1;
    assign frame_num_d = frame_num_q + 16'd1;

    // NOTE: state registers use non-blocking assignments only, so every branch below reads
    // the pre-edge values of x_q/y_q/frame_num_q regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            bar_q        <= '0;
            bar_cnt_q    <= '0;
            gap_q        <= '0;
            sel_q        <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tuser_q      <= 1'b0;
            tlast_q      <= 1'b0;
            frame_done_q <= 1'b0;
            frame_num_q  <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        sel_q    <= pattern_sel;
                        tdata_q  <= pixel(pattern_sel, '0, '0, frame_num_q, 3'd0);
                        tvalid_q <= 1'b1;
                        tuser_q  <= 1'b1;
                        state_q  <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (tvalid_q && m_axis_video.tready) begin
                        tuser_q <= 1'b0;
                        if (x_q != X_LAST) begin
                            x_q       <= x_inc_d;
                            bar_q     <= bar_d;
                            bar_cnt_q <= bar_cnt_d;
                            tdata_q   <= pixel(sel_q, x_inc_d, y_q, frame_num_q, bar_d);
                            tlast_q   <= (x_inc_d == X_LAST);
                        end else begin
                            x_q       <= '0;
                            bar_q     <= '0;
                            bar_cnt_q <= '0;
                            tlast_q   <= 1'b0;
                            if (y_q != Y_LAST) begin
                                y_q     <= y_inc_d;
                                tdata_q <= pixel(sel_q, '0, y_inc_d, frame_num_q, 3'd0);
                                if (H_GAP > 0) begin
                                    tvalid_q <= 1'b0;
                                    gap_q    <= H_GAP_LD;
                                    state_q  <= HGAP;
                                end
                            end else begin
                                y_q          <= '0;
                                frame_done_q <= 1'b1;
                                frame_num_q  <= frame_num_d;
                                if (V_GAP > 0) begin
                                    tvalid_q <= 1'b0;
                                    gap_q    <= V_GAP_LD;
                                    state_q  <= VGAP;
                                end else if (enable) begin
                                    // Back-to-back frame: its first pixel already sees the new count.
                                    sel_q   <= pattern_sel;
                                    tdata_q <= pixel(pattern_sel, '0, '0, frame_num_d, 3'd0);
                                    tuser_q <= 1'b1;
                                end else begin
                                    tvalid_q <= 1'b0;
                                    state_q  <= IDLE;
                                end
                            end
                        end
                    end
                end
                HGAP: begin
                    if (gap_q == '0) begin
                        tvalid_q <= 1'b1;
                        state_q  <= ACTIVE;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: begin
                    if (gap_q != '0) begin
                        gap_q <= gap_q - 1'b1;
                    end else if (enable) begin
                        sel_q    <= pattern_sel;
                        tdata_q  <= pixel(pattern_sel, '0, '0, frame_num_q, 3'd0);
                        tvalid_q <= 1'b1;
                        tuser_q  <= 1'b1;
                        state_q  <= ACTIVE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign m_axis_video.tdata  = tdata_q;
    assign m_axis_video.tvalid = tvalid_q;
    assign m_axis_video.tuser  = tuser_q;
    assign m_axis_video.tlast  = tlast_q;
    assign frame_done          = frame_done_q;
    assign frame_num           = frame_num_q;

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// Scoreboard bench for axis_video_pattern_gen: one instance with line/frame gaps, one without.
module tb_axis_video_pattern_gen;

    localparam int H  = 16;
    localparam int V  = 4;
    localparam int HG = 2;
    localparam int VG = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        en0 = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic        frame_done, frame_done0;
    logic [15:0] frame_num, frame_num0;

    always #5 clk = ~clk;

    axis_video_pattern_gen_if vif();
    axis_video_pattern_gen_if vif0();

    axis_video_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .H_GAP(HG), .V_GAP(VG)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .pattern_sel  (pattern_sel),
        .m_axis_video (vif),
        .frame_done   (frame_done),
        .frame_num    (frame_num)
    );

    axis_video_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .H_GAP(0), .V_GAP(0)) dut0 (
        .clk          (clk),
        .rst          (rst),
        .enable       (en0),
        .pattern_sel  (pattern_sel),
        .m_axis_video (vif0),
        .frame_done   (frame_done0),
        .frame_num    (frame_num0)
    );

    typedef struct {
        logic [23:0] data;
        logic        user;
        logic        last;
        logic        eof;
        int          lead;   // idle cycles expected before this beat, -1 = unchecked
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          passes = 0;
    int          idle_run = 0;
    int          line_beats = 0;
    int          beats_acc = 0;
    logic        fd_pending = 1'b0;
    logic        prev_stall = 1'b0;
    logic [26:0] prev_bus = '0;
    logic [15:0] fn_model = '0;
    logic        use0 = 1'b0;
    logic        rand_rdy = 1'b0;
    logic        rdy = 1'b1;
    logic [23:0] bar_rgb [8];

    function automatic logic [23:0] model_pixel(input int sel, input int x, input int y,
                                                input logic [15:0] fn);
        logic [7:0] xb;
        logic [7:0] yb;
        xb = x[7:0];
        yb = y[7:0];
        case (sel)
            0:       return bar_rgb[x / (H / 8)];
            1:       return {xb, xb, xb};
            2:       return (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
            default: return {fn[7:0], yb, xb};
        endcase
    endfunction

    task automatic push_frame(input int sel, input logic [15:0] fn, input int first_lead,
                              input int hgap);
        beat_t b;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                b.data = model_pixel(sel, x, y, fn);
                b.user = (x == 0 && y == 0);
                b.last = (x == H - 1);
                b.eof  = (x == H - 1 && y == V - 1);
                b.lead = (x != 0) ? 0 : ((y == 0) ? first_lead : hgap);
                exp_q.push_back(b);
            end
        end
    endtask

    // One negedge of scoreboard monitoring on the selected instance.
    task automatic step();
        logic [23:0] d;
        logic        v, u, l, fd, hs;
        logic [15:0] fno;
        beat_t       e;
        @(negedge clk);
        rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        vif.tready  = rdy;
        vif0.tready = rdy;
        d   = use0 ? vif0.tdata  : vif.tdata;
        v   = use0 ? vif0.tvalid : vif.tvalid;
        u   = use0 ? vif0.tuser  : vif.tuser;
        l   = use0 ? vif0.tlast  : vif.tlast;
        fd  = use0 ? frame_done0 : frame_done;
        fno = use0 ? frame_num0  : frame_num;

        checks++;
        if (fd !== fd_pending) $display("FAIL frame_done: got %b expected %b", fd, fd_pending);
        else passes++;
        if (fd_pending) begin
            checks++;
            if (fno !== fn_model) $display("FAIL frame_num: got %0d expected %0d", fno, fn_model);
            else passes++;
        end
        fd_pending = 1'b0;

        if (prev_stall) begin
            checks++;
            if ({v, u, l, d} !== prev_bus)
                $display("FAIL stall_hold: got %h expected %h", {v, u, l, d}, prev_bus);
            else passes++;
        end
        hs         = v && rdy;
        prev_stall = v && !rdy;
        prev_bus   = {v, u, l, d};
        if (v !== 1'b1) idle_run++;

        if (hs) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_beat: got tdata %h expected no beat", d);
            end else begin
                e = exp_q.pop_front();
                if ({d, u, l} !== {e.data, e.user, e.last})
                    $display("FAIL beat: got data %h user %b last %b expected data %h user %b last %b",
                             d, u, l, e.data, e.user, e.last);
                else passes++;
                if (e.lead >= 0) begin
                    checks++;
                    if (idle_run != e.lead)
                        $display("FAIL idle_gap: got %0d expected %0d", idle_run, e.lead);
                    else passes++;
                end
                if (e.eof) begin
                    fd_pending = 1'b1;
                    fn_model   = fn_model + 16'd1;
                end
            end
            idle_run = 0;
            beats_acc++;
            line_beats++;
            if (l === 1'b1) begin
                checks++;
                if (line_beats != H) $display("FAIL line_len: got %0d expected %0d", line_beats, H);
                else passes++;
                line_beats = 0;
            end
        end
    endtask

    task automatic drain(input int leave, input int budget);
        int n = 0;
        while (exp_q.size() > leave && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() > leave) begin
            $display("FAIL drain_timeout: got %0d outstanding expected %0d", exp_q.size(), leave);
            exp_q.delete();
        end else passes++;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b0;
        en0 = 1'b0;
        rand_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        fn_model = '0;
        fd_pending = 1'b0;
        prev_stall = 1'b0;
        idle_run = 0;
        line_beats = 0;
        beats_acc = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({vif.tvalid, vif.tuser, vif.tlast, vif.tdata, frame_done, frame_num} !== 43'd0)
            $display("FAIL reset_state: got %h expected 0",
                     {vif.tvalid, vif.tuser, vif.tlast, vif.tdata, frame_done, frame_num});
        else passes++;
        checks++;
        if ({vif0.tvalid, frame_done0, frame_num0} !== 18'd0)
            $display("FAIL reset_state0: got %h expected 0", {vif0.tvalid, frame_done0, frame_num0});
        else passes++;
        rst = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_coordinate();
        reset_dut();
        pattern_sel = 2'd3;
        enable = 1'b1;
        idle_run = 0;
        push_frame(3, 16'd0, 0, HG);
        push_frame(3, 16'd1, VG, HG);
        drain(32, 1000);
        enable = 1'b0;
        drain(0, 1000);
        repeat (8) step();
        checks++;
        if ({vif.tvalid, frame_num} !== {1'b0, 16'd2})
            $display("FAIL coord_end: got %h expected %h", {vif.tvalid, frame_num}, {1'b0, 16'd2});
        else passes++;
    endtask

    task automatic test_colour_bars();
        pattern_sel = 2'd0;
        enable = 1'b1;
        idle_run = 0;
        push_frame(0, fn_model, 0, HG);
        step();
        enable = 1'b0;
        drain(0, 1000);
        repeat (6) step();
    endtask

    task automatic test_backpressure();
        rand_rdy = 1'b1;
        pattern_sel = 2'd1;
        enable = 1'b1;
        idle_run = 0;
        push_frame(1, fn_model, 0, HG);
        push_frame(3, fn_model + 16'd1, VG, HG);
        step();
        pattern_sel = 2'd3;
        drain(32, 4000);
        enable = 1'b0;
        drain(0, 4000);
        repeat (8) step();
        rand_rdy = 1'b0;
    endtask

    task automatic test_enable_drop();
        int n = 0;
        reset_dut();
        pattern_sel = 2'd3;
        enable = 1'b1;
        idle_run = 0;
        push_frame(3, 16'd0, 0, HG);
        while (beats_acc < 20 && n < 200) begin
            step();
            n++;
        end
        enable = 1'b0;
        drain(0, 1000);
        repeat (8) step();
        checks++;
        if (vif.tvalid !== 1'b0) $display("FAIL idle_after_drop: got %b expected 0", vif.tvalid);
        else passes++;
        enable = 1'b1;
        idle_run = 0;
        push_frame(3, 16'd1, 0, HG);
        step();
        enable = 1'b0;
        drain(0, 1000);
        repeat (6) step();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        reset_dut();
        pattern_sel = 2'd3;
        enable = 1'b1;
        idle_run = 0;
        push_frame(3, 16'd0, 0, HG);
        push_frame(3, 16'd1, VG, HG);
        while (beats_acc < H * V + 30 && n < 1000) begin
            step();
            n++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({vif.tvalid, vif.tuser, frame_done, frame_num} !== 19'd0)
            $display("FAIL mid_reset: got %h expected 0", {vif.tvalid, vif.tuser, frame_done, frame_num});
        else passes++;
        rst = 1'b0;
        exp_q.delete();
        fn_model = '0;
        fd_pending = 1'b0;
        prev_stall = 1'b0;
        line_beats = 0;
        idle_run = 0;
        push_frame(3, 16'd0, 0, HG);
        step();
        enable = 1'b0;
        drain(0, 1000);
        repeat (6) step();
    endtask

    task automatic test_back_to_back();
        reset_dut();
        use0 = 1'b1;
        pattern_sel = 2'd3;
        en0 = 1'b1;
        idle_run = 0;
        push_frame(3, 16'd0, 0, 0);
        push_frame(3, 16'd1, 0, 0);
        drain(32, 1000);
        en0 = 1'b0;
        drain(0, 1000);
        repeat (6) step();
        checks++;
        if ({vif0.tvalid, frame_num0} !== {1'b0, 16'd2})
            $display("FAIL b2b_end: got %h expected %h", {vif0.tvalid, frame_num0}, {1'b0, 16'd2});
        else passes++;
        use0 = 1'b0;
    endtask

    initial begin
        bar_rgb[0] = 24'hFFFFFF; bar_rgb[1] = 24'hFFFF00;
        bar_rgb[2] = 24'h00FFFF; bar_rgb[3] = 24'h00FF00;
        bar_rgb[4] = 24'hFF00FF; bar_rgb[5] = 24'hFF0000;
        bar_rgb[6] = 24'h0000FF; bar_rgb[7] = 24'h000000;
        vif.tready  = 1'b1;
        vif0.tready = 1'b1;
        test_reset();
        test_coordinate();
        test_colour_bars();
        test_backpressure();
        test_enable_drop();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
